// File: rtl/tm_pkg.sv
// Shared definitions for the master-side credit traffic manager.
//   TM_ORDERED / TM_UNORDERED : values for the ORDERED parameter
//   tm_pack_entry             : builds a FIFO entry {data, vc, dest, slave}
package tm_pkg;

  localparam int TM_ORDERED   = 1;
  localparam int TM_UNORDERED = 0;

  // Widest entry the packing helper can build. Callers zero-extend each
  // field to this width and cast the result back to their entry width.
  localparam int TM_PACK_W = 128;

  function automatic logic [TM_PACK_W-1:0] tm_pack_entry(
    input logic [TM_PACK_W-1:0] data,
    input logic [TM_PACK_W-1:0] vc,
    input logic [TM_PACK_W-1:0] dest,
    input logic [TM_PACK_W-1:0] slave,
    input int                   vc_w,
    input int                   dest_w,
    input int                   slave_w
  );
    return (data << (vc_w + dest_w + slave_w)) |
           (vc   << (dest_w + slave_w))         |
           (dest << slave_w)                    |
           slave;
  endfunction

endpackage

// File: rtl/tm_sync_fifo.sv
// Synchronous FIFO with registered count and wrapping pointers.
//   push/din    : write an entry (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   head        : entry at the read pointer
//   count       : number of stored entries
//   full/empty  : derived from count
// DEPTH must be a power of 2 so the pointers wrap naturally.
module tm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tm_master_multislave_pc.sv
// Credit-based traffic manager between a master bundle and the NoC send port.
//   send_*_in        : request from the master (accepted when send_ready_out)
//   send_slave_in    : slave index whose credit pool the request consumes
//   send_*_out       : registered one-cycle flit towards the NoC
//   send_ready_in    : NoC accepts a flit this cycle
//   receive_valid/receive_slave : reply returned, gives back one credit
//   outstanding_total: sum of all per-slave counters
//   credit_err       : sticky; return underflow or illegal slave index
module tm_master_multislave_pc
  import tm_pkg::*;
#(
  parameter int NUM_SLAVES       = 4,
  parameter int NUM_CREDITS      = 8,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 2,
  parameter int WIDTH_DATA       = 36,
  parameter int FIFO_DEPTH       = 4,
  parameter int ORDERED          = TM_ORDERED,
  parameter int SLAVE_W          = $clog2(NUM_SLAVES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        send_valid_in,
  output logic                        send_ready_out,
  input  logic [WIDTH_DATA-1:0]       send_data_in,
  input  logic [ADDRESS_WIDTH-1:0]    send_dest_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] send_vc_in,
  input  logic [SLAVE_W-1:0]          send_slave_in,
  output logic                        send_valid_out,
  output logic [WIDTH_DATA-1:0]       send_data_out,
  output logic [ADDRESS_WIDTH-1:0]    send_dest_out,
  output logic [VC_ADDRESS_WIDTH-1:0] send_vc_out,
  input  logic                        send_ready_in,
  input  logic                        receive_valid,
  input  logic [SLAVE_W-1:0]          receive_slave,
  output logic [$clog2(NUM_SLAVES*NUM_CREDITS+1)-1:0] outstanding_total,
  output logic                        credit_err
);

  localparam int CNT_W   = $clog2(NUM_CREDITS + 1);
  localparam int TOT_W   = $clog2(NUM_SLAVES * NUM_CREDITS + 1);
  localparam int DST_W   = VC_ADDRESS_WIDTH + ADDRESS_WIDTH;
  localparam int ENTRY_W = WIDTH_DATA + DST_W + SLAVE_W;
  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [SLAVE_W:0] NS_LIM   = (SLAVE_W + 1)'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(NUM_CREDITS);

  logic [ENTRY_W-1:0]          fifo_din;
  logic [ENTRY_W-1:0]          head;
  logic [FCNT_W-1:0]           fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;

  logic [SLAVE_W-1:0]          head_slave;
  logic [ADDRESS_WIDTH-1:0]    head_dest;
  logic [VC_ADDRESS_WIDTH-1:0] head_vc;
  logic [WIDTH_DATA-1:0]       head_data;

  logic [CNT_W-1:0]            cnt [NUM_SLAVES];
  logic [DST_W-1:0]            last_dst;

  logic                        head_idx_ok;
  logic                        rx_idx_ok;
  logic [CNT_W-1:0]            head_cnt;
  logic [CNT_W-1:0]            rx_cnt;
  logic                        order_ok;
  logic                        launch;
  logic                        ret_ok;
  logic                        err_evt;
  logic [NUM_SLAVES-1:0]       inc_vec;
  logic [NUM_SLAVES-1:0]       dec_vec;

  assign fifo_din = ENTRY_W'(tm_pack_entry(TM_PACK_W'(send_data_in), TM_PACK_W'(send_vc_in),
                                           TM_PACK_W'(send_dest_in), TM_PACK_W'(send_slave_in),
                                           VC_ADDRESS_WIDTH, ADDRESS_WIDTH, SLAVE_W));

  assign send_ready_out = (fifo_count != FCNT_W'(FIFO_DEPTH));
  assign push           = send_valid_in & ~fifo_full;

  tm_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FCNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (launch),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_slave = head[SLAVE_W-1:0];
  assign head_dest  = head[SLAVE_W +: ADDRESS_WIDTH];
  assign head_vc    = head[SLAVE_W + ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
  assign head_data  = head[ENTRY_W-1 -: WIDTH_DATA];

  // Eligibility and credit returns look only at registered counters, so a
  // return never opens a launch in the same cycle.
  always_comb begin
    head_idx_ok = ({1'b0, head_slave} < NS_LIM);
    rx_idx_ok   = ({1'b0, receive_slave} < NS_LIM);
    head_cnt    = head_idx_ok ? cnt[head_slave] : '0;
    rx_cnt      = rx_idx_ok ? cnt[receive_slave] : '0;
    order_ok    = (ORDERED == TM_UNORDERED) ||
                  ({head_vc, head_dest} == last_dst) ||
                  (outstanding_total == '0);
    launch      = !fifo_empty && send_ready_in && head_idx_ok &&
                  (head_cnt < CRED_MAX) && order_ok;
    ret_ok      = receive_valid && rx_idx_ok && (rx_cnt != '0);
    // A head with an illegal slave index never launches and flags forever.
    err_evt     = (receive_valid && !ret_ok) || (!fifo_empty && !head_idx_ok);
    inc_vec     = '0;
    dec_vec     = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      inc_vec[s] = launch && (head_slave == SLAVE_W'(s));
      dec_vec[s] = ret_ok && (receive_slave == SLAVE_W'(s));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      send_valid_out    <= 1'b0;
      send_data_out     <= '0;
      send_dest_out     <= '0;
      send_vc_out       <= '0;
      last_dst          <= '0;
      outstanding_total <= '0;
      credit_err        <= 1'b0;
      for (int s = 0; s < NUM_SLAVES; s++) cnt[s] <= '0;
    end else begin
      send_valid_out <= launch;
      send_data_out  <= launch ? head_data : '0;
      send_dest_out  <= launch ? head_dest : '0;
      send_vc_out    <= launch ? head_vc   : '0;
      if (launch) last_dst <= {head_vc, head_dest};
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (inc_vec[s] && !dec_vec[s])      cnt[s] <= cnt[s] + CNT_W'(1);
        else if (dec_vec[s] && !inc_vec[s]) cnt[s] <= cnt[s] - CNT_W'(1);
      end
      if (launch && !ret_ok)      outstanding_total <= outstanding_total + TOT_W'(1);
      else if (ret_ok && !launch) outstanding_total <= outstanding_total - TOT_W'(1);
      if (err_evt) credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tm_master_multislave_pc.sv
// Bench for tm_master_multislave_pc: one ordered and one unordered instance
// share the same stimulus and are both compared every cycle against a
// queue-based model of the request/credit rules.
module tb_tm_master_multislave_pc;

  localparam int NS    = 4;
  localparam int NC    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [35:0] data;
    logic [1:0]  vc;
    logic [3:0]  dest;
    logic [1:0]  slave;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_valid_in;
  logic [35:0] send_data_in;
  logic [3:0]  send_dest_in;
  logic [1:0]  send_vc_in;
  logic [1:0]  send_slave_in;
  logic        send_ready_in;
  logic        receive_valid;
  logic [1:0]  receive_slave;

  logic        rdy_o  [2];
  logic        vout_o [2];
  logic [35:0] dout_o [2];
  logic [3:0]  dest_o [2];
  logic [1:0]  vc_o   [2];
  logic [5:0]  tot_o  [2];
  logic        err_o  [2];

  always #5 clk = ~clk;

  tm_master_multislave_pc #(.ORDERED(1)) u_ord (
    .clk(clk), .rst(rst),
    .send_valid_in(send_valid_in), .send_ready_out(rdy_o[0]),
    .send_data_in(send_data_in), .send_dest_in(send_dest_in),
    .send_vc_in(send_vc_in), .send_slave_in(send_slave_in),
    .send_valid_out(vout_o[0]), .send_data_out(dout_o[0]),
    .send_dest_out(dest_o[0]), .send_vc_out(vc_o[0]),
    .send_ready_in(send_ready_in),
    .receive_valid(receive_valid), .receive_slave(receive_slave),
    .outstanding_total(tot_o[0]), .credit_err(err_o[0])
  );

  tm_master_multislave_pc #(.ORDERED(0)) u_unord (
    .clk(clk), .rst(rst),
    .send_valid_in(send_valid_in), .send_ready_out(rdy_o[1]),
    .send_data_in(send_data_in), .send_dest_in(send_dest_in),
    .send_vc_in(send_vc_in), .send_slave_in(send_slave_in),
    .send_valid_out(vout_o[1]), .send_data_out(dout_o[1]),
    .send_dest_out(dest_o[1]), .send_vc_out(vc_o[1]),
    .send_ready_in(send_ready_in),
    .receive_valid(receive_valid), .receive_slave(receive_slave),
    .outstanding_total(tot_o[1]), .credit_err(err_o[1])
  );

  // Model state, index 0 = ordered instance, 1 = unordered instance.
  ent_t        mq [2][$];
  int          mcnt [2][NS];
  int          mtot [2];
  logic [5:0]  mlast [2];
  logic        merr [2];
  logic        ev [2];
  logic [35:0] ed [2];
  logic [3:0]  edst [2];
  logic [1:0]  evc [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock using the inputs present at the edge.
  task automatic model_step();
    ent_t h;
    ent_t e;
    bit   launch;
    bit   ret;
    bit   can_push;
    int   rs;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mq[m].delete();
        for (int s = 0; s < NS; s++) mcnt[m][s] = 0;
        mtot[m] = 0; mlast[m] = '0; merr[m] = 1'b0;
        ev[m] = 1'b0; ed[m] = '0; edst[m] = '0; evc[m] = '0;
      end else begin
        launch   = 1'b0;
        ret      = 1'b0;
        rs       = 0;
        h        = '0;
        can_push = (mq[m].size() < DEPTH);
        if (mq[m].size() > 0 && send_ready_in) begin
          h = mq[m][0];
          if (int'(h.slave) < NS && mcnt[m][h.slave] < NC &&
              (m == 1 || {h.vc, h.dest} == mlast[m] || mtot[m] == 0))
            launch = 1'b1;
        end
        if (receive_valid) begin
          rs = int'(receive_slave);
          if (rs < NS && mcnt[m][rs] > 0) ret = 1'b1;
          else merr[m] = 1'b1;
        end
        if (launch) begin
          void'(mq[m].pop_front());
          mcnt[m][h.slave]++;
          mtot[m]++;
          mlast[m] = {h.vc, h.dest};
          ev[m] = 1'b1; ed[m] = h.data; edst[m] = h.dest; evc[m] = h.vc;
        end else begin
          ev[m] = 1'b0; ed[m] = '0; edst[m] = '0; evc[m] = '0;
        end
        if (ret) begin
          mcnt[m][rs]--;
          mtot[m]--;
        end
        if (can_push && send_valid_in) begin
          e.data = send_data_in; e.vc = send_vc_in;
          e.dest = send_dest_in; e.slave = send_slave_in;
          mq[m].push_back(e);
        end
      end
    end
  endtask

  task automatic compare();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("valid%0d", m), 64'(vout_o[m]), 64'(ev[m]));
      chk($sformatf("data%0d", m),  64'(dout_o[m]), 64'(ed[m]));
      chk($sformatf("dest%0d", m),  64'(dest_o[m]), 64'(edst[m]));
      chk($sformatf("vc%0d", m),    64'(vc_o[m]),   64'(evc[m]));
      chk($sformatf("ready%0d", m), 64'(rdy_o[m]),  64'(mq[m].size() != DEPTH));
      chk($sformatf("total%0d", m), 64'(tot_o[m]),  64'(mtot[m]));
      chk($sformatf("err%0d", m),   64'(err_o[m]),  64'(merr[m]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clear_inputs();
    send_valid_in = 1'b0;
    send_data_in  = '0;
    send_dest_in  = '0;
    send_vc_in    = '0;
    send_slave_in = '0;
    receive_valid = 1'b0;
    receive_slave = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] slave, input logic [3:0] dest, input logic [1:0] vc);
    send_valid_in = 1'b1;
    send_slave_in = slave;
    send_dest_in  = dest;
    send_vc_in    = vc;
    send_data_in  = 36'($urandom) ^ (36'($urandom) << 4);
  endtask

  initial begin
    clear_inputs();
    send_ready_in = 1'b1;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_ready", 64'(rdy_o[0]), 64'd1);
    chk("rst_valid", 64'(vout_o[0]), 64'd0);
    chk("rst_total", 64'(tot_o[1]), 64'd0);
    chk("rst_err",   64'(err_o[0]), 64'd0);

    // 1: three requests to slave 1, dest 5.
    for (int i = 0; i < 3; i++) begin
      set_req(2'd1, 4'd5, 2'd0);
      cycle();
    end
    clear_inputs();
    cycle();
    chk("t1_third_flit", 64'(vout_o[0]), 64'd1);
    cycle();
    chk("t1_after_burst", 64'(vout_o[0]), 64'd0);
    chk("t1_total", 64'(tot_o[0]), 64'd3);

    // 2: credit exhaustion on slave 0, then one return frees one launch.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_req(2'd0, 4'd1, 2'd0);
      cycle();
    end
    clear_inputs();
    repeat (3) cycle();
    chk("t2_total_cap", 64'(tot_o[0]), 64'd8);
    chk("t2_stalled", 64'(vout_o[0]), 64'd0);
    receive_valid = 1'b1;
    receive_slave = 2'd0;
    cycle();
    clear_inputs();
    cycle();
    chk("t2_ninth_launch", 64'(vout_o[0]), 64'd1);
    cycle();
    chk("t2_total_again", 64'(tot_o[0]), 64'd8);

    // 3: destination switch under ordered and unordered modes.
    do_reset();
    set_req(2'd2, 4'd3, 2'd0); cycle();
    set_req(2'd2, 4'd3, 2'd0); cycle();
    set_req(2'd2, 4'd7, 2'd0); cycle();
    clear_inputs();
    cycle();
    chk("t3_unord_dest7", 64'(dest_o[1]), 64'd7);
    chk("t3_ord_held", 64'(vout_o[0]), 64'd0);
    cycle();
    chk("t3_ord_total", 64'(tot_o[0]), 64'd2);
    receive_valid = 1'b1;
    receive_slave = 2'd2;
    cycle();
    cycle();
    clear_inputs();
    chk("t3_ord_drained", 64'(tot_o[0]), 64'd0);
    cycle();
    chk("t3_ord_launch", 64'(vout_o[0]), 64'd1);
    chk("t3_ord_dest7", 64'(dest_o[0]), 64'd7);

    // 4: launch and return on slave 0 in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(2'd0, 4'd1, 2'd0);
      cycle();
    end
    clear_inputs();
    repeat (3) cycle();
    set_req(2'd0, 4'd1, 2'd0);
    cycle();
    clear_inputs();
    receive_valid = 1'b1;
    receive_slave = 2'd0;
    cycle();
    clear_inputs();
    chk("t4_same_launch", 64'(vout_o[0]), 64'd1);
    cycle();
    chk("t4_total", 64'(tot_o[0]), 64'd4);
    chk("t4_no_err", 64'(err_o[0]), 64'd0);

    // 5: underflow on slave 3 is sticky until reset.
    receive_valid = 1'b1;
    receive_slave = 2'd3;
    cycle();
    clear_inputs();
    repeat (3) cycle();
    chk("t5_err_sticky", 64'(err_o[0]), 64'd1);
    chk("t5_total_kept", 64'(tot_o[0]), 64'd4);
    do_reset();
    chk("t5_err_cleared", 64'(err_o[0]), 64'd0);

    // 6: fill the FIFO with the NoC blocked, then drain and reset mid-stream.
    send_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(2'd1, 4'd2, 2'd1);
      cycle();
    end
    chk("t6_full", 64'(rdy_o[0]), 64'd0);
    set_req(2'd1, 4'd9, 2'd1);
    cycle();
    clear_inputs();
    send_ready_in = 1'b1;
    cycle();
    chk("t6_ready_back", 64'(rdy_o[0]), 64'd1);
    chk("t6_first_dest", 64'(dest_o[0]), 64'd2);
    set_req(2'd1, 4'd2, 2'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_inputs();
    chk("t6_rst_valid", 64'(vout_o[0]), 64'd0);
    chk("t6_rst_total", 64'(tot_o[0]), 64'd0);
    chk("t6_rst_ready", 64'(rdy_o[0]), 64'd1);
    repeat (2) cycle();
    chk("t6_flushed", 64'(vout_o[0]), 64'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst           = ($urandom_range(0, 149) == 0);
      send_valid_in = ($urandom_range(0, 2) != 0);
      send_slave_in = 2'($urandom_range(0, 3));
      send_dest_in  = ($urandom_range(0, 1) == 0) ? 4'd2 : 4'd5;
      send_vc_in    = 2'($urandom_range(0, 1));
      send_data_in  = 36'($urandom) ^ (36'($urandom) << 4);
      send_ready_in = ($urandom_range(0, 3) != 0);
      receive_valid = ($urandom_range(0, 2) == 0);
      receive_slave = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
